// File: rtl/adc_pkg.sv
// Shared ADC sample types and the offset-binary to magnitude helper.
package adc_pkg;

  localparam int unsigned ADC_W   = 12;
  localparam int unsigned ADC_MID = 2048;

  typedef logic [ADC_W-1:0] adc_sample_t;

  // Distance from mid-scale; 0 maps to ADC_MID, which still fits in ADC_W bits.
  function automatic adc_sample_t adc_mag(input adc_sample_t s);
    if (s >= adc_sample_t'(ADC_MID)) begin
      return s - adc_sample_t'(ADC_MID);
    end else begin
      return adc_sample_t'(ADC_MID) - s;
    end
  endfunction

endpackage

// File: rtl/adc_block_energy.sv
// Accumulates per-block magnitude sum, peak and error count of the ADC sample
// stream and hands each block result downstream over a valid/ready handshake.
module adc_block_energy
  import adc_pkg::*;
#(
  parameter  int unsigned DATA_W    = 12,
  parameter  int unsigned BLOCK_LEN = 64,
  localparam int unsigned SUM_W     = DATA_W + $clog2(BLOCK_LEN),
  localparam int unsigned CNT_W     = $clog2(BLOCK_LEN) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_error,
  output logic [SUM_W-1:0]  out_sum,
  output logic [DATA_W-1:0] out_peak,
  output logic [CNT_W-1:0]  out_err_cnt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun_o
);

  logic [SUM_W-1:0]  r_acc;
  logic [DATA_W-1:0] r_peak;
  logic [CNT_W-1:0]  r_err;
  logic [CNT_W-1:0]  r_cnt;

  logic [SUM_W-1:0]  r_out_sum;
  logic [DATA_W-1:0] r_out_peak;
  logic [CNT_W-1:0]  r_out_err;
  logic              r_out_valid;
  logic              r_overrun;

  logic [DATA_W-1:0] w_mag;
  logic [SUM_W-1:0]  w_acc_nxt;
  logic [DATA_W-1:0] w_peak_nxt;
  logic [CNT_W-1:0]  w_err_nxt;
  logic              w_accept;
  logic              w_last;
  logic              w_load;

  assign w_mag    = DATA_W'(adc_mag(ADC_W'(in_data)));
  assign w_accept = en && in_valid;
  assign w_last   = w_accept && (r_cnt == CNT_W'(BLOCK_LEN - 1));
  // A finished block may load if the output slot is empty or draining this edge.
  assign w_load   = w_last && (!r_out_valid || out_ready);

  // Running totals including the sample currently presented.
  always_comb begin
    w_acc_nxt  = r_acc;
    w_peak_nxt = r_peak;
    w_err_nxt  = r_err;
    if (in_error) begin
      w_err_nxt = r_err + CNT_W'(1);
    end else begin
      w_acc_nxt = r_acc + SUM_W'(w_mag);
      if (w_mag > r_peak) begin
        w_peak_nxt = w_mag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_peak      <= '0;
      r_err       <= '0;
      r_cnt       <= '0;
      r_out_sum   <= '0;
      r_out_peak  <= '0;
      r_out_err   <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (!en) begin
        r_acc     <= '0;
        r_peak    <= '0;
        r_err     <= '0;
        r_cnt     <= '0;
        r_overrun <= 1'b0;
      end else if (w_accept) begin
        if (w_last) begin
          r_acc  <= '0;
          r_peak <= '0;
          r_err  <= '0;
          r_cnt  <= '0;
          if (!w_load) begin
            r_overrun <= 1'b1;
          end
        end else begin
          r_acc  <= w_acc_nxt;
          r_peak <= w_peak_nxt;
          r_err  <= w_err_nxt;
          r_cnt  <= r_cnt + CNT_W'(1);
        end
      end

      // Output slot: load wins over a same-edge accept so the stream has no bubble.
      if (w_load) begin
        r_out_sum   <= w_acc_nxt;
        r_out_peak  <= w_peak_nxt;
        r_out_err   <= w_err_nxt;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_sum     = r_out_sum;
  assign out_peak    = r_out_peak;
  assign out_err_cnt = r_out_err;
  assign out_valid   = r_out_valid;
  assign overrun_o   = r_overrun;

endmodule

// File: tb/tb_adc_block_energy.sv
// Directed scoreboard bench for adc_block_energy with BLOCK_LEN=4.
module tb_adc_block_energy;

  localparam int unsigned DATA_W    = 12;
  localparam int unsigned BLOCK_LEN = 4;
  localparam int unsigned SUM_W     = DATA_W + $clog2(BLOCK_LEN);
  localparam int unsigned CNT_W     = $clog2(BLOCK_LEN) + 1;

  typedef struct packed {
    logic [SUM_W-1:0]  sum;
    logic [DATA_W-1:0] peak;
    logic [CNT_W-1:0]  err;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_error;
  logic [SUM_W-1:0]  out_sum;
  logic [DATA_W-1:0] out_peak;
  logic [CNT_W-1:0]  out_err_cnt;
  logic              out_valid;
  logic              out_ready;
  logic              overrun_o;

  int   checks;
  int   failures;
  exp_t sb_q[$];

  // Reference model of the block currently being collected.
  int   m_sum;
  int   m_peak;
  int   m_err;
  int   m_cnt;

  adc_block_energy #(
    .DATA_W   (DATA_W),
    .BLOCK_LEN(BLOCK_LEN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_error   (in_error),
    .out_sum    (out_sum),
    .out_peak   (out_peak),
    .out_err_cnt(out_err_cnt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overrun_o  (overrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_sum  = 0;
    m_peak = 0;
    m_err  = 0;
    m_cnt  = 0;
  endtask

  // Drive one sample pulse; the model pushes an expected result on block end.
  task automatic sample(input int d, input logic e);
    int   mag;
    exp_t x;
    mag = d - 2048;
    if (mag < 0) mag = -mag;
    if (e) m_err++;
    else begin
      m_sum += mag;
      if (mag > m_peak) m_peak = mag;
    end
    m_cnt++;
    if (m_cnt == BLOCK_LEN) begin
      x.sum  = SUM_W'(m_sum);
      x.peak = DATA_W'(m_peak);
      x.err  = CNT_W'(m_err);
      sb_q.push_back(x);
      model_clear();
    end
    in_data  = DATA_W'(d);
    in_error = e;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_error = 1'b0;
  endtask

  // Compare the presented result with the oldest scoreboard entry.
  task automatic check_result(input string tag);
    exp_t x;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
    end else begin
      x = sb_q.pop_front();
      chk({tag, "_sum"}, 32'(out_sum), 32'(x.sum));
      chk({tag, "_peak"}, 32'(out_peak), 32'(x.peak));
      chk({tag, "_err"}, 32'(out_err_cnt), 32'(x.err));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_sum"}, 32'(out_sum), 32'd0);
    chk({tag, "_peak"}, 32'(out_peak), 32'd0);
    chk({tag, "_err"}, 32'(out_err_cnt), 32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun_o), 32'd0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    en        = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    in_error  = 1'b0;
    out_ready = 1'b1;
    model_clear();
    tick();
    tick();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Basic block
    sample(2048, 1'b0);
    sample(2148, 1'b0);
    sample(1948, 1'b0);
    chk("basic_not_early", 32'(out_valid), 32'd0);
    sample(4095, 1'b0);
    chk("basic_const_sum", 32'(out_sum), 32'd2247);
    check_result("basic");
    tick();
    chk("basic_one_cycle", 32'(out_valid), 32'd0);

    // Error sample excluded from sum and peak
    sample(0, 1'b0);
    sample(2048, 1'b0);
    sample(2000, 1'b1);
    sample(2058, 1'b0);
    chk("err_const_sum", 32'(out_sum), 32'd2058);
    chk("err_const_peak", 32'(out_peak), 32'd2048);
    check_result("errsub");
    tick();

    // Backpressure: second block is dropped
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) sample(1000, 1'b0);
    chk("bp_first_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      sample(3000, 1'b0);
      chk("bp_hold_sum", 32'(out_sum), 32'd4192);
    end
    chk("bp_overrun", 32'(overrun_o), 32'd1);
    void'(sb_q.pop_back());
    check_result("bp_first");
    out_ready = 1'b1;
    tick();
    chk("bp_accepted", 32'(out_valid), 32'd0);
    chk("bp_overrun_sticky", 32'(overrun_o), 32'd1);
    en = 1'b0;
    model_clear();
    tick();
    chk("bp_overrun_clr", 32'(overrun_o), 32'd0);
    en = 1'b1;
    tick();

    // Same-edge accept and load
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) sample(100, 1'b0);
    check_result("sim_first");
    for (int i = 0; i < 3; i++) sample(4000, 1'b0);
    out_ready = 1'b1;
    sample(4000, 1'b0);
    chk("sim_overrun", 32'(overrun_o), 32'd0);
    chk("sim_const_sum", 32'(out_sum), 32'd7808);
    check_result("sim_second");
    tick();
    chk("sim_drained", 32'(out_valid), 32'd0);

    // en low discards the partial block
    sample(100, 1'b0);
    sample(200, 1'b1);
    en = 1'b0;
    model_clear();
    tick();
    en = 1'b1;
    for (int i = 0; i < 4; i++) sample(2548, 1'b0);
    chk("en_const_sum", 32'(out_sum), 32'd2000);
    check_result("en_partial");
    tick();

    // Asynchronous reset with a pending result and a partial block
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) sample(2148, 1'b0);
    check_result("rst_pending");
    sample(0, 1'b0);
    sample(0, 1'b0);
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    check_idle_outputs("rst_async");
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    sample(2248, 1'b0);
    sample(2248, 1'b0);
    chk("rst_cnt_cleared", 32'(out_valid), 32'd0);
    sample(2248, 1'b0);
    sample(2248, 1'b0);
    chk("rst_const_sum", 32'(out_sum), 32'd800);
    check_result("rst_next");
    tick();

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
